// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// One access is in flight at a time; read data is returned with a one-cycle done pulse.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH  = 7,
   parameter int DATA_WIDTH  = 16,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  done0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  done1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   // state   | meaning
   // S_IDLE  | sample requests, grant round-robin, latch the winner's access
   // S_ISSUE | drive mem_en for one cycle, load the latency counter
   // S_WAIT  | count down memory latency, capture read data at terminal count
   // S_RESP  | pulse done for the owner port
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  last_grant_q, last_grant_d;
   logic                  owner_q, owner_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  grant_port;

   // On a tie the port that did not win last time takes the grant.
   assign grant_port = (req0 && req1) ? ~last_grant_q : req1;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               owner_d      = grant_port;
               last_grant_d = grant_port;
               we_d         = grant_port ? we1    : we0;
               addr_d       = grant_port ? addr1  : addr0;
               wdata_d      = grant_port ? wdata1 : wdata0;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               if (!we_q) rdata_d = mem_rdata;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
      end
   end

   // Write enable is only presented alongside the strobe.
   assign mem_en    = (state_q == S_ISSUE);
   assign mem_we    = mem_en && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign done0     = (state_q == S_RESP) && !owner_q;
   assign done1     = (state_q == S_RESP) &&  owner_q;
   assign busy      = (state_q != S_IDLE);
   assign rdata     = rdata_q;

endmodule
